// File: rtl/sc_conv_arbiter.sv
// Round-robin scheduler that time-shares one binary-to-pulse stochastic converter
// among NREQ requesters and returns each stream's '1'-pulse count.
module sc_conv_arbiter #(
  parameter int  NREQ  = 4,
  parameter int  WIDTH = 16,
  parameter int  LEN_W = 10,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_value,
  output logic [NREQ-1:0]       req_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic [WIDTH-1:0]      conv_value,
  output logic                  conv_en,
  input  logic                  conv_pulse,
  output logic                  sc_bit,
  output logic [ID_W-1:0]       sc_id,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [LEN_W-1:0]      res_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  value_q;
  logic [LEN_W-1:0]  remain_q;
  logic [LEN_W-1:0]  count_q;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              accept;

  // Search starts at ptr; the id arithmetic wraps naturally because NREQ is a power of two.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[ptr_q + ID_W'(k)]) begin
        grant_any = 1'b1;
        grant_id  = ptr_q + ID_W'(k);
      end
    end
  end

  // Gated by rst_n so req_ready is also 0 while reset is held.
  assign accept    = rst_n && (state_q == S_IDLE) && grant_any;
  assign req_ready = accept ? (NREQ'(1'b1) << grant_id) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (cfg_len != '0) ? S_RUN : S_DONE;
      S_RUN:  if (remain_q == LEN_W'(1)) state_d = S_DONE;
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The last RUN cycle adds its pulse like any other, so count_q holds the final result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      id_q     <= '0;
      value_q  <= '0;
      remain_q <= '0;
      count_q  <= '0;
    end else if (accept) begin
      ptr_q    <= grant_id + 1'b1;
      id_q     <= grant_id;
      value_q  <= req_value[grant_id*WIDTH +: WIDTH];
      remain_q <= cfg_len;
      count_q  <= '0;
    end else if (state_q == S_RUN) begin
      remain_q <= remain_q - 1'b1;
      count_q  <= count_q + LEN_W'(conv_pulse);
    end
  end

  assign conv_en    = (state_q == S_RUN);
  assign conv_value = conv_en ? value_q : '0;
  assign sc_bit     = conv_pulse & conv_en;
  assign sc_id      = id_q;
  assign res_valid  = (state_q == S_DONE);
  assign res_id     = id_q;
  assign res_count  = count_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/sc_conv_arbiter.md
# sc_conv_arbiter

Round-robin scheduler that time-shares one binary-to-pulse stochastic converter (LFSR plus 16-bit comparator) among NREQ requesters. Each requester submits a binary value. The block then:
- drives the value into the shared converter for a configured number of cycles;
- forwards the resulting pulse stream, tagged with the requester id;
- accumulates the number of '1' pulses, which is the stream's stochastic-to-binary readback;
- returns the count through a valid/ready result port.

It sits between the reservoir-node front ends and the single shared converter instance.

## Interface
- NREQ, 4, number of requesters (power of two, 2..8)
- WIDTH, 16, binary value width (matches converter input)
- LEN_W, 10, stream-length and count width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_value  in  NREQ*WIDTH  packed values; requester i uses bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept strobe
- cfg_len  in  LEN_W  stream length in cycles, sampled on accept
- conv_value  out  WIDTH  value driven to the converter's binary input
- conv_en  out  1  converter stream active (LFSR enable)
- conv_pulse  in  1  converter output (combinational from conv_value)
- sc_bit  out  1  forwarded pulse, equal to conv_pulse & conv_en
- sc_id  out  log2(NREQ)  owner of the current stream
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_id  out  log2(NREQ)  requester id of the result
- res_count  out  LEN_W  number of '1' pulses in the stream
- busy  out  1  state is not IDLE

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - If any req_valid is high, pick a winner g by round-robin starting at pointer ptr.
  - req_ready[g] is asserted combinationally in the same cycle.
  - At the clock edge, capture req_value[g], cfg_len and g, and set ptr to (g+1) mod NREQ.
  - Go to RUN if cfg_len != 0, or to DONE with count 0 if cfg_len == 0.
  - req_ready is never asserted outside IDLE.
- **RUN**
  - conv_en = 1 and conv_value = captured value.
  - Each cycle: count += conv_pulse and remaining -= 1.
  - On the cycle where remaining == 1, the final count (including that cycle's pulse) is registered and the FSM goes to DONE.
- **DONE**
  - res_valid = 1; res_count and res_id are held stable.
  - When res_ready is high at an edge, go to IDLE.
  - No new request is accepted until IDLE.
- Outside RUN: conv_en = 0, conv_value = 0 and sc_bit = 0. sc_id holds the last owner.
- Arithmetic:
  - count and remaining are LEN_W bits.
  - The maximum length is 2^LEN_W - 1, so count cannot overflow.
- Requester behaviour:
  - A requester may drop req_valid before being granted; it is then not served.
  - req_value must be stable while req_valid is high.
- Reset (asynchronous, valid at any time, including mid-RUN or in DONE):
  - Every output goes to 0; ptr = 0; state = IDLE.
  - Any in-flight stream is discarded and no result is produced for it.

## Timing
- Accept edge k → RUN cycles k+1 .. k+L, where L = cfg_len.
- res_valid is high from cycle k+L+1 until the res_ready handshake.
- Handshake edge m → IDLE at m+1; earliest next accept is edge m+1.
- Minimum period per stream is L+2 cycles (res_ready held high).
- cfg_len == 0: res_valid in cycle k+1 with res_count = 0, and conv_en is never raised.
- sc_bit and sc_id are valid in the same cycle as conv_pulse; no added latency.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait and keep req_valid high.
- Fairness: a continuously requesting requester is served within NREQ streams.

## Test plan
- **Single stream, all pulses:** conv_pulse tied to 1, req 0 with value 0x8000, cfg_len = 100 → conv_en high exactly 100 cycles, res_count = 100, res_id = 0, res_valid at accept + 101.
- **Pattern counting:** bench converter model drives conv_pulse = 1 on every 3rd RUN cycle, cfg_len = 30 → res_count = 10, and sc_bit matches conv_pulse with sc_id = requester id.
- **Round-robin order:** all 4 requesters hold req_valid, cfg_len = 5, res_ready = 1 → grant order 0, 1, 2, 3, 0, one grant every 7 cycles, one-hot req_ready.
- **Zero length:** cfg_len = 0 → res_valid one cycle after accept, res_count = 0, conv_en stays 0.
- **Result back-pressure:** res_ready held low for 20 cycles in DONE → res_valid, res_count and res_id are stable, and req_ready stays 0 despite pending requests.
- **Mid-stream reset:** assert rst_n low at RUN cycle 10 of a 50-cycle stream → all outputs 0 immediately. After release, the first grant goes to requester 0 and no stale result appears.
